// File: rtl/clock_pkg.sv
// clock_pkg
//   Definitions shared by the input handler and the clock state storage so
//   both ends of the cursor interface agree on encodings.
//   - CLK_HZ: board clock frequency, used to derive default timing parameters.
//   - CURSOR_*: one-hot field-select encodings carried on cursorPos.
//   - holdState_t: long-press reset machine states (IDLE / HOLDING).
//   - cursorLeft / cursorRight: one-hot cursor rotation helpers.
package clock_pkg;

  localparam int CLK_HZ = 100_000_000;

  localparam logic [2:0] CURSOR_SEC  = 3'b001;
  localparam logic [2:0] CURSOR_MIN  = 3'b010;
  localparam logic [2:0] CURSOR_HOUR = 3'b100;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDING = 1'b1
  } holdState_t;

  // Move toward hours, wrapping. Any non-one-hot value recovers to seconds.
  function automatic logic [2:0] cursorLeft(input logic [2:0] c);
    case (c)
      CURSOR_SEC:  return CURSOR_MIN;
      CURSOR_MIN:  return CURSOR_HOUR;
      default:     return CURSOR_SEC;
    endcase
  endfunction

  // Move toward seconds, wrapping. Any non-one-hot value recovers to seconds.
  function automatic logic [2:0] cursorRight(input logic [2:0] c);
    case (c)
      CURSOR_SEC:  return CURSOR_HOUR;
      CURSOR_HOUR: return CURSOR_MIN;
      default:     return CURSOR_SEC;
    endcase
  endfunction

endpackage

// File: rtl/input_handler_if.sv
// input_handler_if
//   Bundles the raw board buttons and the command outputs of input_handler.
//   Protocol: there is no valid/ready handshake. up, down and reset are
//   single-cycle strobes that the consumer must act on in the cycle they are
//   high; cursorPos is a level that is always exactly one-hot.
//   holdState exposes the long-press machine state for observation.
//   Modports:
//     master - board/driver side: drives buttons, observes outputs.
//     slave  - input_handler side: reads buttons, drives outputs.
interface input_handler_if;
  import clock_pkg::*;

  logic       btnUp;
  logic       btnDown;
  logic       btnLeft;
  logic       btnRight;
  logic       btnCenter;
  logic       up;
  logic       down;
  logic       reset;
  logic [2:0] cursorPos;
  holdState_t holdState;

  modport master (
    output btnUp, btnDown, btnLeft, btnRight, btnCenter,
    input  up, down, reset, cursorPos, holdState
  );

  modport slave (
    input  btnUp, btnDown, btnLeft, btnRight, btnCenter,
    output up, down, reset, cursorPos, holdState
  );

endinterface

// File: rtl/input_handler_button_debouncer.sv
// button_debouncer
//   Two-flop synchroniser, debounce counter and rising-edge detector for one
//   raw push-button.
//   Ports: clk, rst (async, active-high), btnRaw (asynchronous button pin),
//          level (debounced pressed level), rise (1-cycle debounced press).
//   The synchroniser and debounced level reset to "pressed" and level stays
//   low until a debounced release has been seen, so a button held across
//   reset produces neither a press edge nor a held level until it is
//   released and pressed again.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          debPrev;
  logic          armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      deb     <= 1'b1;
      debPrev <= 1'b1;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btnRaw;
      sync2   <= sync1;
      debPrev <= deb;
      armed   <= armed | ~deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = deb & armed;
  assign rise  = deb & ~debPrev;

endmodule

// File: rtl/input_handler.sv
// input_handler
//   Turns the five raw board buttons into single-cycle up/down/reset command
//   pulses and a one-hot cursor position for the clock state storage.
//   Ports: clk, rst (async, active-high), bus (input_handler_if.slave:
//          btnUp/btnDown/btnLeft/btnRight/btnCenter in; up, down, reset,
//          cursorPos, holdState out).
//   Optional feature: define INPUT_HANDLER_AUTO_REPEAT_EN to make a held
//   up/down button repeat after REPEAT_DELAY cycles, then every
//   REPEAT_PERIOD cycles. Without it each press gives exactly one pulse.
module input_handler
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = CLK_HZ / 100,
  parameter int RESET_HOLD_CYCLES = 2 * CLK_HZ,
  parameter int REPEAT_DELAY      = CLK_HZ / 2,
  parameter int REPEAT_PERIOD     = CLK_HZ / 5
) (
  input logic            clk,
  input logic            rst,
  input_handler_if.slave bus
);

  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  // The hold counter parks one past the firing value so it cannot re-fire.
  localparam logic [HW-1:0] HOLD_FIRE = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(RESET_HOLD_CYCLES);

  logic upLvl, upRise, downLvl, downRise;
  logic leftLvl, leftRise, rightLvl, rightRise;
  logic centerLvl, centerRise;
  logic repUp, repDown;
  logic holdFire;

  logic          upQ, downQ, resetQ;
  logic [2:0]    cursorQ;
  holdState_t    state;
  logic [HW-1:0] holdCnt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUp (
    .clk(clk), .rst(rst), .btnRaw(bus.btnUp), .level(upLvl), .rise(upRise));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDown (
    .clk(clk), .rst(rst), .btnRaw(bus.btnDown), .level(downLvl), .rise(downRise));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLeft (
    .clk(clk), .rst(rst), .btnRaw(bus.btnLeft), .level(leftLvl), .rise(leftRise));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRight (
    .clk(clk), .rst(rst), .btnRaw(bus.btnRight), .level(rightLvl), .rise(rightRise));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uCenter (
    .clk(clk), .rst(rst), .btnRaw(bus.btnCenter), .level(centerLvl), .rise(centerRise));

  // Cursor buttons and the center button act on edges / levels only.
  logic unusedLevels;
  assign unusedLevels = leftLvl ^ rightLvl ^ centerRise;

`ifdef INPUT_HANDLER_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] repCnt;
  logic          repPhase;  // 0: waiting out the initial delay, 1: periodic
  logic          oneHeld;
  logic          repFire;

  // Repeating only runs with exactly one of up/down held; any fresh press
  // restarts the delay from the pulse it produces.
  assign oneHeld = upLvl ^ downLvl;
  assign repFire = oneHeld & ~upRise & ~downRise &
                   (repPhase ? (repCnt == RW'(REPEAT_PERIOD - 1))
                             : (repCnt == RW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repCnt   <= '0;
      repPhase <= 1'b0;
    end else if (!oneHeld || upRise || downRise) begin
      repCnt   <= '0;
      repPhase <= 1'b0;
    end else if (repFire) begin
      repCnt   <= '0;
      repPhase <= 1'b1;
    end else begin
      repCnt <= repCnt + 1'b1;
    end
  end

  assign repUp   = repFire & upLvl;
  assign repDown = repFire & downLvl;
`else
  localparam int unusedRepeatCfg = REPEAT_DELAY + REPEAT_PERIOD;
  logic unusedRepeatLvls;
  assign unusedRepeatLvls = upLvl ^ downLvl;
  assign repUp   = 1'b0;
  assign repDown = 1'b0;
`endif

  assign holdFire = (state == HOLDING) && centerLvl && (holdCnt == HOLD_FIRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upQ     <= 1'b0;
      downQ   <= 1'b0;
      resetQ  <= 1'b0;
      cursorQ <= CURSOR_SEC;
      state   <= IDLE;
      holdCnt <= '0;
    end else begin
      // Simultaneous up and down presses cancel each other.
      upQ    <= (upRise & ~downRise) | repUp;
      downQ  <= (downRise & ~upRise) | repDown;
      resetQ <= holdFire;

      if (holdFire) begin
        cursorQ <= CURSOR_SEC;
      end else if (leftRise && !rightRise) begin
        cursorQ <= cursorLeft(cursorQ);
      end else if (rightRise && !leftRise) begin
        cursorQ <= cursorRight(cursorQ);
      end

      case (state)
        IDLE: begin
          holdCnt <= '0;
          if (centerLvl) begin
            state <= HOLDING;
          end
        end
        HOLDING: begin
          if (!centerLvl) begin
            state   <= IDLE;
            holdCnt <= '0;
          end else if (holdCnt != HOLD_SAT) begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          holdCnt <= '0;
        end
      endcase
    end
  end

  assign bus.up        = upQ;
  assign bus.down      = downQ;
  assign bus.reset     = resetQ;
  assign bus.cursorPos = cursorQ;
  assign bus.holdState = state;

endmodule

// File: doc/input_handler.md
Name: input_handler

Overview:
- Converts the five raw board push-buttons into the single-cycle command pulses and the cursor position consumed by the clock state storage block.
- Command outputs: up, down, reset pulses; cursorPos one-hot field select.
- Sits between the board button pins and the clock storage.
- Handles synchronisation, debouncing, edge detection, cursor movement and long-press reset detection.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised button must hold a new level before the debounced state changes (10 ms at 100 MHz).
- RESET_HOLD_CYCLES, 200000000, cycles btnCenter must stay debounced-pressed before reset fires (2 s).
- REPEAT_DELAY, 50000000, AUTO_REPEAT_EN only: hold time before the first repeat.
- REPEAT_PERIOD, 20000000, AUTO_REPEAT_EN only: interval between repeats.

Ports:
- clk  input  1  100 MHz onboard clock
- rst  input  1  asynchronous active-high reset
- btnUp  input  1  raw up button, asynchronous, active-high
- btnDown  input  1  raw down button, asynchronous, active-high
- btnLeft  input  1  raw left button, moves cursor toward hours
- btnRight  input  1  raw right button, moves cursor toward seconds
- btnCenter  input  1  raw center button, long press requests clock reset
- up  output  1  one-cycle increment pulse
- down  output  1  one-cycle decrement pulse
- reset  output  1  one-cycle clock-clear pulse
- cursorPos  output  3  one-hot field select: 001 seconds, 010 minutes, 100 hours

Behaviour:
- Reset and clock:
  - One clock (clk). rst is asynchronous and active-high.
  - While rst is high, all flops clear and outputs are up=0, down=0, reset=0, cursorPos=3'b001.
  - Release of rst is synchronous to clk.
  - Asserting rst mid-operation aborts any debounce, hold or repeat count in progress. No pulse is emitted on rst release, even if a button is already held; that button must be released and pressed again.
- Input path, per button:
  - Two-flop synchroniser feeding a debouncer.
  - The debounce counter clears whenever the synchronised level equals the debounced level.
  - The counter increments while the two levels differ.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Edge detect compares the debounced level against its value one cycle earlier.
  - Press-to-pulse latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 registered output cycle.
- up and down:
  - Each is a registered pulse, exactly 1 cycle wide, on the debounced rising edge of its button.
  - If both rising edges occur in the same cycle, neither pulse is emitted.
  - If one button is already held, a rising edge on the other is still emitted.
- Cursor:
  - Left rising edge rotates the one-hot value left: 001->010->100->001 (wraps).
  - Right rising edge rotates it right: 001->100->010->001 (wraps).
  - Left and right rising edges in the same cycle leave cursorPos unchanged.
  - cursorPos updates in the same registered cycle as the pulses would and is always exactly one-hot.
- Long-press reset:
  - Two-state machine: IDLE and HOLDING.
  - IDLE -> HOLDING on debounced btnCenter = 1; the hold counter starts at 0.
  - In HOLDING the counter increments every cycle while btnCenter stays pressed.
  - When the counter reaches RESET_HOLD_CYCLES-1, a 1-cycle reset pulse is emitted and cursorPos is forced to 3'b001 in the same cycle. The forced value overrides any simultaneous left/right move.
  - After firing, the machine stays in HOLDING with the counter saturated. No further reset pulse fires until btnCenter is released.
  - Debounced release at any point returns to IDLE with the counter cleared. A short press does nothing.
- Pulses may coincide: reset and up in the same cycle are both asserted.
- Counter widths are sized with $clog2 of their parameter. There is no overflow: all counters saturate or clear.

Optional Feature:
- Macro: INPUT_HANDLER_AUTO_REPEAT_EN.
- Defined:
  - While up (or down) remains debounced-held, a repeat counter runs.
  - The first extra pulse fires REPEAT_DELAY cycles after the initial pulse. Further pulses follow every REPEAT_PERIOD cycles.
  - Release stops repeating immediately and clears the counter.
  - If up and down are both held, repeating is suppressed.
  - A cursor change while holding does not restart the counter.
- Undefined: exactly one pulse per press. REPEAT_DELAY and REPEAT_PERIOD are accepted but unused.

Decomposition:
- Shared package (clock_pkg):
  - Cursor encodings CURSOR_SEC=3'b001, CURSOR_MIN=3'b010, CURSOR_HOUR=3'b100.
  - CLK_HZ=100000000.
  - Input-handler state encoding (IDLE/HOLDING).
- These are shared with the clock state storage block so both ends of the cursor interface agree.
- One sub-module, button_debouncer: synchroniser, debounce counter, debounced level, rise output. It is parameterised by DEBOUNCE_CYCLES and instantiated 5 times.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=16, REPEAT_DELAY=10, REPEAT_PERIOD=5.)
- btnUp bounces 1,0,1 over 3 cycles, then holds high 20 cycles -> exactly one up pulse, asserted 7 cycles after the stable high begins; down=0 throughout.
- btnLeft pressed/released 4 times from reset -> cursorPos 010,100,001,010. Then btnRight once -> 001.
- btnUp and btnDown rising in the same cycle -> no up or down pulse. btnLeft and btnRight together -> cursorPos unchanged.
- btnCenter held 30 cycles with cursorPos=100 -> one reset pulse about 16 cycles after debounce, cursorPos becomes 001, no second pulse. A 10-cycle hold gives no pulse.
- rst asserted while btnCenter hold count is 10, btnUp held through release -> outputs zero immediately, cursorPos=001, no pulses after release until btnUp is re-pressed.
- With INPUT_HANDLER_AUTO_REPEAT_EN, btnDown held 40 cycles past debounce -> pulses at offsets 0, 10, 15, 20, 25, 30, 35. Without the macro -> a single pulse.
